sw_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the 8-to-3 priority encoder and seven-segment decoder on the lab board. It synchronises the eight code switches and the enable switch into the clock domain and debounces each line independently. It drives the stable 8-bit code and enable to the encoder. It also produces per-bit edge pulses and a single change strobe, so later logic can react to a switch event exactly once.

---
 rtl/sw_debounce.sv | 91 +++++++++
 tb/tb_sw_debounce.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Switch conditioning for the encoder: 2-flop synchronisers, per-line debounce counters,
// registered debounced levels plus per-bit rise/fall pulses and a combined change strobe.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_sw,
  input  logic       i_en_sw,
  output logic [7:0] o_code,
  output logic       o_en,
  output logic [7:0] o_rise,
  output logic [7:0] o_fall,
  output logic       o_chg
);

  localparam int unsigned NumCh = 9;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 8 is the enable switch; channels 7..0 are the code switches.
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1_q;
  logic [NumCh-1:0] sync2_q;
  logic [NumCh-1:0] stab_q;
  logic [NumCh-1:0] stab_d;
  logic [NumCh-1:0] commit;

  logic [7:0] rise_q, rise_d;
  logic [7:0] fall_q, fall_d;
  logic       chg_q, chg_d;

  assign raw = {i_en_sw, i_sw};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : gen_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;

    assign differ    = sync2_q[g] != stab_q[g];
    assign commit[g] = differ && (cnt_q == CntLast);
    // Any sample matching the committed level restarts the stability window.
    assign cnt_d     = (differ && !commit[g]) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    stab_d = stab_q ^ commit;
    rise_d = commit[7:0] & sync2_q[7:0];
    fall_d = commit[7:0] & ~sync2_q[7:0];
    chg_d  = |commit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stab_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      stab_q <= stab_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign o_code = stab_q[7:0];
  assign o_en   = stab_q[8];
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_chg  = chg_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: a sliding-window model checked every cycle,
// plus literal expectations at the key edges of each scenario.
module tb_sw_debounce;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       en_sw;
  logic [7:0] o_code, o_rise, o_fall;
  logic       o_en, o_chg;

  int total = 0;
  int bad = 0;
  int chg_seen = 0;
  int c0;

  sw_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_sw   (sw),
    .i_en_sw(en_sw),
    .o_code (o_code),
    .o_en   (o_en),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_chg  (o_chg)
  );

  always #5 clk = ~clk;

  // Model: a line commits once its last D synchronised samples all oppose the committed level.
  // The synchronised sample seen at an edge is the pin value taken two edges earlier.
  logic [8:0] hist [0:D+1];
  logic [8:0] m_stab;
  logic [8:0] m_commit;
  logic [7:0] m_rise, m_fall;
  logic       m_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= D + 1; j++) hist[j] = '0;
      m_stab = '0;
      m_rise = '0;
      m_fall = '0;
      m_chg  = 1'b0;
    end else begin
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {en_sw, sw};
      m_commit = '1;
      for (int j = 2; j <= D + 1; j++) m_commit = m_commit & (hist[j] ^ m_stab);
      m_rise = m_commit[7:0] & hist[2][7:0];
      m_fall = m_commit[7:0] & ~hist[2][7:0];
      m_chg  = |m_commit;
      m_stab = m_stab ^ m_commit;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cycle", {6'd0, o_code, o_en, o_rise, o_fall, o_chg},
        {6'd0, m_stab[7:0], m_stab[8], m_rise, m_fall, m_chg});
    if (o_chg === 1'b1) chg_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 8'hA5;
    en_sw = 1'b1;

    // Reset with switches already high
    cyc(3);
    chk("rst_code", {24'd0, o_code}, 32'h0);
    chk("rst_rise_chg", {23'd0, o_rise, o_chg}, 32'h0);
    #1 rst_n = 1'b1;
    cyc(5);
    chk("rst_pre_commit", {23'd0, o_code, o_en}, 32'h0);
    cyc(1);
    chk("rst_code_en", {23'd0, o_code, o_en}, {23'd0, 8'hA5, 1'b1});
    chk("rst_rise", {24'd0, o_rise}, 32'hA5);
    chk("rst_fall", {24'd0, o_fall}, 32'h0);
    chk("rst_chg", {31'd0, o_chg}, 32'h1);
    cyc(1);
    chk("rst_pulse_end", {23'd0, o_rise, o_chg}, 32'h0);

    // Glitch rejection from a zero code
    sw = 8'h00;
    cyc(10);
    c0 = chg_seen;
    sw[3] = 1'b1;
    cyc(3);
    sw[3] = 1'b0;
    cyc(10);
    chk("glitch_code", {24'd0, o_code}, 32'h0);
    chk("glitch_no_chg", chg_seen - c0, 32'd0);

    // Clean press and release of bit 7
    sw = 8'h80;
    cyc(5);
    chk("press_pre", {24'd0, o_code}, 32'h0);
    cyc(1);
    chk("press_code", {24'd0, o_code}, 32'h80);
    chk("press_rise", {24'd0, o_rise}, 32'h80);
    cyc(4);
    sw = 8'h00;
    cyc(5);
    chk("release_pre", {24'd0, o_code}, 32'h80);
    cyc(1);
    chk("release_code", {24'd0, o_code}, 32'h0);
    chk("release_fall", {24'd0, o_fall}, 32'h80);
    cyc(4);

    // Bounce on bit 0, then hold high
    c0 = chg_seen;
    for (int j = 0; j < 6; j++) begin
      sw[0] = (j % 2 == 0);
      cyc(2);
    end
    sw[0] = 1'b1;
    cyc(5);
    chk("bounce_pre", {24'd0, o_code}, 32'h0);
    chk("bounce_no_early", chg_seen - c0, 32'd0);
    cyc(1);
    chk("bounce_code", {24'd0, o_code}, 32'h01);
    chk("bounce_rise", {24'd0, o_rise}, 32'h01);
    cyc(6);
    chk("bounce_one_pulse", chg_seen - c0, 32'd1);

    // Simultaneous change 0F -> F0
    sw = 8'h0F;
    cyc(10);
    sw = 8'hF0;
    cyc(5);
    chk("simul_pre", {24'd0, o_code}, 32'h0F);
    cyc(1);
    chk("simul_code", {24'd0, o_code}, 32'hF0);
    chk("simul_edges", {15'd0, o_rise, o_fall, o_chg}, {15'd0, 8'hF0, 8'h0F, 1'b1});
    cyc(1);
    chk("simul_end", {15'd0, o_rise, o_fall, o_chg}, 32'h0);

    // Enable toggles low; no code edge pulses
    en_sw = 1'b0;
    cyc(5);
    chk("en_pre", {31'd0, o_en}, 32'h1);
    cyc(1);
    chk("en_fall", {30'd0, o_en, o_chg}, 32'h1);
    chk("en_no_code_edges", {16'd0, o_rise, o_fall}, 32'h0);

    // Reset mid-count on bit 1
    cyc(3);
    sw = 8'hF2;
    cyc(5);
    #1 rst_n = 1'b0;
    #1 chk("midrst_clear", {23'd0, o_code, o_en}, 32'h0);
    cyc(2);
    #1 rst_n = 1'b1;
    cyc(5);
    chk("midrst_pre", {24'd0, o_code}, 32'h0);
    cyc(1);
    chk("midrst_code", {24'd0, o_code}, 32'hF2);
    chk("midrst_rise_chg", {23'd0, o_rise, o_chg}, {23'd0, 8'hF2, 1'b1});
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
